stream_frame_capture: RTL
=========================

Name: stream_frame_capture

Overview:
- Receiving end of the float vld/rdy/fst stream protocol that the stimulus side drives; it sits at the output of a stage or the ingress of a test harness.
- Accepts frames of FRAME_LEN words delimited by fst, aligns them, and stores them in a two-bank ping-pong buffer.
- Replays each complete frame downstream as a clean vld/rdy/fst stream.
- Counts completed frames, short frames and words discarded while out of sync.

Parameters:
- DATA_WIDTH, 32, word width (float_24_8 packed).
- FRAME_LEN, 36, words per frame; must be >= 2.
- ADDR_WIDTH, 6, bank address width; must satisfy 2**ADDR_WIDTH >= FRAME_LEN.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  DATA_WIDTH  input word.
- in_vld  in  1  input word valid.
- in_fst  in  1  marks the first word of a frame.
- in_rdy  out  1  capture can accept a word.
- out_data  out  DATA_WIDTH  replayed word.
- out_vld  out  1  output word valid.
- out_fst  out  1  first word of the replayed frame.
- out_rdy  in  1  downstream accepts the word.
- frame_count  out  CNT_WIDTH  completed frames; wraps.
- short_err_count  out  CNT_WIDTH  frames restarted by an early fst; saturates.
- drop_count  out  CNT_WIDTH  words discarded in SYNC; saturates.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write FSM goes to W_SYNC; wr_bank=0, wr_addr=0, rd_bank=0, rd_addr=0.
  - Both bank-full flags cleared; all counters 0.
  - out_vld=0, out_fst=0, out_data=0.
  - in_rdy=1 once reset is released.
  - Memory contents are not reset.
  - Reset mid-operation discards any partial or stored frames.
- Handshakes:
  - Input accept = in_vld & in_rdy. Output accept = out_vld & out_rdy.
  - in_rdy = ~full[wr_bank], combinational from flags only, never from in_vld.
  - out_vld does not depend on out_rdy.
  - Held data must stay stable while vld=1 and rdy=0.
- W_SYNC state, on accept:
  - fst=0: word discarded; drop_count+1, saturating at all-ones.
  - fst=1: word written to mem[wr_bank][0]; wr_addr=1; go to W_FILL.
- W_FILL state, on accept:
  - fst=1: early restart. short_err_count+1 (saturating); word written at addr 0; wr_addr=1; stay in W_FILL.
  - fst=0: word written at wr_addr; wr_addr+1.
  - If wr_addr==FRAME_LEN-1 at accept (frame complete): full[wr_bank]<=1, wr_bank toggles, wr_addr=0, frame_count+1 (wrapping), go to W_SYNC.
- The word following a complete frame must carry fst; otherwise it is dropped in W_SYNC.
- Read side:
  - out_vld = full[rd_bank], registered.
  - out_data = mem[rd_bank][rd_addr] when out_vld=1, else 0.
  - out_fst = out_vld & (rd_addr==0).
  - On output accept rd_addr+1. At rd_addr==FRAME_LEN-1: full[rd_bank]<=0, rd_bank toggles, rd_addr=0.
- Latency: out_vld rises the cycle after the last word of a frame is accepted.
- Throughput: with out_rdy=1 held, streaming is continuous with no bubbles; the ping-pong banks overlap fill and drain.
- Simultaneous events: a write completion on one bank and a read completion on the other in the same cycle both take effect. Flag set and clear never target the same bank.
- Full condition: both banks full gives in_rdy=0. in_rdy returns to 1 the cycle after the read completion that frees the write bank.
- in_vld=0 cycles inside a frame are legal and leave all state unchanged.

Test Plan:
- Reset, send 36 words with in_data=0x3F800000+i and fst on word 0, out_rdy=1 -> out_vld rises 1 cycle after the 36th accept; 36 words in order; out_fst only on word 0; frame_count=1; other counters 0.
- out_rdy=0, send 3 back-to-back frames -> in_rdy falls after the 72nd accept. Raise out_rdy -> frames 1 and 2 emerge; frame 3 is accepted after frame 1 drains. All 108 words intact; frame_count=3.
- Frame with fst at word 0, then fst again at word 10, followed by 35 more words -> short_err_count=1; exactly one output frame, equal to the 36 words starting at the second fst.
- 5 words with fst=0, then a valid frame -> drop_count=5; output frame correct.
- Assert reset=0 asynchronously at word 20 of the second frame while the first frame is draining -> out_vld, out_fst, out_data and all counters go to 0 immediately. After release, in_rdy=1 and a fresh frame passes correctly.
- Random in_vld/out_rdy (50% each) over 200 frames, with counters preloaded near saturation by forcing the state -> output matches input frame by frame; drop_count/short_err_count hold at 0xFFFF; frame_count wraps from 0xFFFF to 0.

Source files
------------

// File: rtl/stream_frame_capture.sv
// Frame capture for a vld/rdy/fst word stream: aligns frames on fst, stores them in a
// two-bank ping-pong buffer and replays each complete frame downstream.
module stream_frame_capture #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 36,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  input  logic                  in_fst,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  output logic                  out_fst,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  short_err_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic {StSync, StFill} wr_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            full_q, full_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  short_cnt_q, short_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [2][Depth];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  in_acc;
  logic                  out_acc;
  logic                  full_set;
  logic                  full_clr;

  // The write bank is never full while it is being filled, so rdy comes from flags alone.
  assign in_rdy  = ~full_q[wr_bank_q];
  assign in_acc  = in_vld & in_rdy;
  assign out_vld = full_q[rd_bank_q];
  assign out_acc = out_vld & out_rdy;

  assign out_data = out_vld ? mem_q[rd_bank_q][rd_addr_q] : '0;
  assign out_fst  = out_vld & (rd_addr_q == '0);

  assign frame_count     = frame_cnt_q;
  assign short_err_count = short_cnt_q;
  assign drop_count      = drop_cnt_q;

  // Write side: frame alignment and bank filling.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    frame_cnt_d = frame_cnt_q;
    short_cnt_d = short_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    full_set    = 1'b0;
    if (in_acc) begin
      unique case (wr_state_q)
        StSync: begin
          if (in_fst) begin
            mem_we     = 1'b1;
            mem_waddr  = '0;
            wr_addr_d  = ADDR_WIDTH'(1);
            wr_state_d = StFill;
          end else if (drop_cnt_q != CntMax) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
          end
        end
        StFill: begin
          mem_we = 1'b1;
          if (in_fst) begin
            // Early fst restarts the frame in the same bank.
            mem_waddr = '0;
            wr_addr_d = ADDR_WIDTH'(1);
            if (short_cnt_q != CntMax) begin
              short_cnt_d = short_cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            mem_waddr = wr_addr_q;
            if (wr_addr_q == LastAddr) begin
              full_set    = 1'b1;
              wr_bank_d   = ~wr_bank_q;
              wr_addr_d   = '0;
              frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
              wr_state_d  = StSync;
            end else begin
              wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: wr_state_d = StSync;
      endcase
    end
  end

  // Read side: replay the full bank word by word.
  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    full_clr  = 1'b0;
    if (out_acc) begin
      if (rd_addr_q == LastAddr) begin
        full_clr  = 1'b1;
        rd_bank_d = ~rd_bank_q;
        rd_addr_d = '0;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Set targets the write bank (not full), clear targets the read bank (full): never the same.
  always_comb begin
    full_d = full_q;
    if (full_set) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (full_clr) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q  <= StSync;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      full_q      <= '0;
      frame_cnt_q <= '0;
      short_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
      short_cnt_q <= short_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_bank_q][mem_waddr] <= in_data;
    end
  end

endmodule
